// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } arb_state_t;

    localparam int ARB_N        = 5;
    localparam int ARB_MAX_HOLD = 16;

    // Reduce an index sum (at most 2*n-2) back into the range 0..n-1.
    function automatic logic [2:0] wrap_idx(input logic [3:0] sum, input int n);
        logic [3:0] lim;
        logic [2:0] res;
        lim = 4'(n);
        if (sum >= lim) begin
            res = 3'(sum - lim);
        end else begin
            res = sum[2:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first set request at or after ptr, wrapping modulo N.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = ARB_N
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    output logic         valid,
    output logic [2:0]   idx
);

    logic [N-1:0] rot;

    // Doubling the request vector lets a plain shift act as a rotate by ptr.
    assign rot = N'({req, req} >> ptr);

    // Scan from the top down so the lowest rotated position wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                valid = 1'b1;
                idx   = wrap_idx({1'b0, ptr} + 4'(j), N);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_5.sv
// Round-robin arbiter with grant hold, done/drop release and hold timeout.
module rr_arbiter_5
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int MAX_HOLD = ARB_MAX_HOLD
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] gnt,
    output logic [2:0]   gnt_id,
    output logic         busy,
    output logic         timeout
);

    localparam int            CW        = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [2:0]    ptr;
    logic [2:0]    ptr_nxt;
    logic [2:0]    owner;
    logic [2:0]    owner_nxt;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] hold_nxt;
    logic [N-1:0]  gnt_nxt;
    logic [2:0]    gnt_id_nxt;
    logic          busy_nxt;
    logic          timeout_nxt;

    logic          pick_valid;
    logic [2:0]    pick_idx;
    logic          owner_req;
    logic          hold_expired;

    rr_pick #(
        .N(N)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign owner_req    = req[owner];
    assign hold_expired = (hold_cnt == HOLD_LAST);

    // Next-state logic; outputs are computed one cycle ahead so they leave registered.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        owner_nxt   = owner;
        hold_nxt    = hold_cnt;
        gnt_nxt     = gnt;
        gnt_id_nxt  = gnt_id;
        busy_nxt    = busy;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                gnt_nxt    = '0;
                gnt_id_nxt = '0;
                busy_nxt   = 1'b0;
                if (pick_valid) begin
                    state_nxt  = GRANT;
                    owner_nxt  = pick_idx;
                    hold_nxt   = '0;
                    gnt_nxt    = {{(N-1){1'b0}}, 1'b1} << pick_idx;
                    gnt_id_nxt = pick_idx;
                    busy_nxt   = 1'b1;
                end
            end
            GRANT: begin
                if (done || !owner_req || hold_expired) begin
                    state_nxt   = RELEASE;
                    gnt_nxt     = '0;
                    gnt_id_nxt  = '0;
                    busy_nxt    = 1'b1;
                    // A timeout is only flagged when the hold limit alone ended the grant.
                    timeout_nxt = hold_expired && !done && owner_req;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            RELEASE: begin
                state_nxt  = IDLE;
                ptr_nxt    = wrap_idx({1'b0, owner} + 4'd1, N);
                gnt_nxt    = '0;
                gnt_id_nxt = '0;
                busy_nxt   = 1'b0;
            end
            default: begin
                state_nxt  = IDLE;
                gnt_nxt    = '0;
                gnt_id_nxt = '0;
                busy_nxt   = 1'b0;
            end
        endcase
    end

    // State, pointer, counter and output registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
            hold_cnt <= hold_nxt;
            gnt      <= gnt_nxt;
            gnt_id   <= gnt_id_nxt;
            busy     <= busy_nxt;
            timeout  <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_5.sv
// Directed bench for rr_arbiter_5 with a queue of expected output snapshots.
module tb_rr_arbiter_5;

    typedef struct packed {
        logic [4:0] gnt;
        logic [2:0] gnt_id;
        logic       busy;
        logic       timeout;
    } snap_t;

    logic       clock;
    logic       reset_n;
    logic [4:0] req;
    logic       done;
    logic [4:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       timeout;

    snap_t exp_q[$];
    string tag_q[$];
    int    passed;
    int    total;

    rr_arbiter_5 dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [4:0] oh(input int a);
        return 5'(1 << a);
    endfunction

    task automatic apply_stimulus(input logic [4:0] r, input logic d);
        req  = r;
        done = d;
    endtask

    task automatic expect_out(input logic [4:0] g, input logic [2:0] id,
                              input logic b, input logic t, input string tag);
        exp_q.push_back({g, id, b, t});
        tag_q.push_back(tag);
    endtask

    task automatic check_output();
        snap_t e;
        snap_t o;
        string tag;
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        o   = {gnt, gnt_id, busy, timeout};
        total++;
        assert (o === e) passed++;
        else begin
            $error("[TB] FAIL %s: observed gnt=%b id=%0d busy=%b timeout=%b, expected gnt=%b id=%0d busy=%b timeout=%b",
                   tag, o.gnt, o.gnt_id, o.busy, o.timeout, e.gnt, e.gnt_id, e.busy, e.timeout);
        end
    endtask

    // Drive inputs for the next rising edge, then compare at the following falling edge.
    task automatic step(input logic [4:0] r, input logic d, input logic [4:0] g,
                        input logic [2:0] id, input logic b, input logic t, input string tag);
        apply_stimulus(r, d);
        expect_out(g, id, b, t, tag);
        @(negedge clock);
        check_output();
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        reset_n = 1'b1;
        req     = 5'b11111;
        done    = 1'b0;

        #1 reset_n = 1'b0;
        #1;
        expect_out(5'b0, 3'd0, 1'b0, 1'b0, "reset_async");
        check_output();
        @(negedge clock);
        expect_out(5'b0, 3'd0, 1'b0, 1'b0, "reset_held_edge");
        check_output();
        @(negedge clock);
        reset_n = 1'b1;

        $display("[TB] first grant and rotation");
        step(5'b11111, 1'b0, oh(0), 3'd0, 1'b1, 1'b0, "first_grant_agent0");
        for (int a = 0; a < 5; a++) begin
            int nxt;
            nxt = (a + 1) % 5;
            step(5'b11111, 1'b0, oh(a), 3'(a), 1'b1, 1'b0, "rot_hold");
            step(5'b11111, 1'b1, 5'b0, 3'd0, 1'b1, 1'b0, "rot_release");
            step(5'b11111, 1'b0, 5'b0, 3'd0, 1'b0, 1'b0, "rot_idle");
            step(5'b11111, 1'b0, oh(nxt), 3'(nxt), 1'b1, 1'b0, "rot_grant");
        end

        $display("[TB] timeout on agent 3");
        step(5'b01000, 1'b0, 5'b0, 3'd0, 1'b1, 1'b0, "drop0_release");
        step(5'b01000, 1'b0, 5'b0, 3'd0, 1'b0, 1'b0, "drop0_idle");
        step(5'b01000, 1'b0, oh(3), 3'd3, 1'b1, 1'b0, "to_grant");
        for (int c = 0; c < 15; c++) begin
            step(5'b01000, 1'b0, oh(3), 3'd3, 1'b1, 1'b0, "to_hold");
        end
        step(5'b01000, 1'b0, 5'b0, 3'd0, 1'b1, 1'b1, "to_pulse");
        step(5'b01000, 1'b0, 5'b0, 3'd0, 1'b0, 1'b0, "to_idle");
        step(5'b01000, 1'b0, oh(3), 3'd3, 1'b1, 1'b0, "to_regrant");

        $display("[TB] request drop on agent 2");
        step(5'b00100, 1'b0, 5'b0, 3'd0, 1'b1, 1'b0, "drop3_release");
        step(5'b00100, 1'b0, 5'b0, 3'd0, 1'b0, 1'b0, "drop3_idle");
        step(5'b00100, 1'b0, oh(2), 3'd2, 1'b1, 1'b0, "a2_grant");
        step(5'b00100, 1'b0, oh(2), 3'd2, 1'b1, 1'b0, "a2_cycle2");
        step(5'b00100, 1'b0, oh(2), 3'd2, 1'b1, 1'b0, "a2_cycle3");
        step(5'b11010, 1'b0, 5'b0, 3'd0, 1'b1, 1'b0, "a2_drop_release");
        step(5'b11010, 1'b0, 5'b0, 3'd0, 1'b0, 1'b0, "a2_drop_idle");
        step(5'b11010, 1'b0, oh(3), 3'd3, 1'b1, 1'b0, "after_drop_agent3");

        $display("[TB] done coinciding with hold limit");
        for (int c = 0; c < 15; c++) begin
            step(5'b11010, 1'b0, oh(3), 3'd3, 1'b1, 1'b0, "sim_hold");
        end
        step(5'b11010, 1'b1, 5'b0, 3'd0, 1'b1, 1'b0, "sim_release_no_timeout");
        step(5'b10000, 1'b1, 5'b0, 3'd0, 1'b0, 1'b0, "sim_idle");
        step(5'b10001, 1'b1, oh(4), 3'd4, 1'b1, 1'b0, "ptr4_grant_agent4");
        step(5'b10001, 1'b0, oh(4), 3'd4, 1'b1, 1'b0, "agent4_hold");

        $display("[TB] asynchronous reset mid-grant");
        #2 reset_n = 1'b0;
        #1;
        expect_out(5'b0, 3'd0, 1'b0, 1'b0, "midgrant_reset_async");
        check_output();
        @(negedge clock);
        expect_out(5'b0, 3'd0, 1'b0, 1'b0, "midgrant_reset_held");
        check_output();
        reset_n = 1'b1;
        step(5'b10001, 1'b0, oh(0), 3'd0, 1'b1, 1'b0, "post_reset_agent0");
        step(5'b00000, 1'b0, 5'b0, 3'd0, 1'b1, 1'b0, "final_release");
        step(5'b00000, 1'b0, 5'b0, 3'd0, 1'b0, 1'b0, "final_idle");
        step(5'b00000, 1'b0, 5'b0, 3'd0, 1'b0, 1'b0, "idle_no_req");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
